// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC dual-rail receive path.
package noc_pkg;

   // Default packet geometry
   localparam int unsigned NOC_WID_DEF = 16;
   localparam int unsigned CNT_WID_DEF = 8;

   // Receive FSM state encoding
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACK_HI = 2'b01,
      ACK_LO = 2'b10,
      EMIT   = 2'b11
   } state_t;

   // Dual-rail symbol codes: rail 1 carries a one, rail 0 carries a zero
   localparam logic [1:0] DR_SPACER  = 2'b00;
   localparam logic [1:0] DR_ZERO    = 2'b01;
   localparam logic [1:0] DR_ONE     = 2'b10;
   localparam logic [1:0] DR_ILLEGAL = 2'b11;

endpackage

// File: rtl/noc_pkt_fifo.sv
// Synchronous packet FIFO with full/empty flags; head word is visible on o_data.
module noc_pkt_fifo #(
   parameter int unsigned WID   = 25,
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_push,
   input  logic [WID-1:0] i_data,
   input  logic           i_pop,
   output logic [WID-1:0] o_data,
   output logic           o_full,
   output logic           o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WID-1:0] r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic           w_rd;
   logic           w_wr;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_rd    = i_pop && !o_empty;
   // a push into a full FIFO is accepted only when a pop frees the slot in the same cycle
   assign w_wr    = i_push && (!o_full || w_rd);
   assign o_data  = r_mem[r_rd_ptr];

   // Storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[AW'(i)] <= '0;
         end
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/noc_rx_deser.sv
// Dual-rail NoC receive deserializer: 4-phase req/ack front end, MSB-first
// shift register, packet emit over valid/ready with ack-withholding backpressure.
// Build option: define NOC_RX_DESER_FIFO_EN for a DEPTH-entry output FIFO;
// otherwise a single output register holds one packet.
module noc_rx_deser
   import noc_pkg::*;
#(
   parameter int unsigned NOC_WID = NOC_WID_DEF,
   parameter int unsigned CNT_WID = CNT_WID_DEF,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_rx_req,
   input  logic [1:0]         i_rx_d,
   output logic               o_rx_ack,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [NOC_WID-1:0] o_out_data,
   output logic [CNT_WID-1:0] o_out_bits,
   output logic               o_out_err
);

   localparam int unsigned PKT_WID = 1 + CNT_WID + NOC_WID;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("noc_rx_deser: DEPTH must be a power of two >= 2");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NOC_WID-1:0] r_sr;
   logic [CNT_WID-1:0] r_cnt;
   logic               r_err;
   logic               w_clr;
   logic               w_shift;
   logic               w_bad;
   logic               w_push;
   logic               w_slot_free;
   logic [PKT_WID-1:0] w_pkt;

   assign w_pkt    = {r_err, r_cnt, r_sr};
   assign o_rx_ack = (r_state == ACK_HI);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_shift     = 1'b0;
      w_bad       = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         IDLE: begin
            w_clr = 1'b1;
            if (i_rx_req) begin
               w_state_nxt = ACK_HI;
            end
         end
         ACK_HI: begin
            case (i_rx_d)
               DR_ZERO, DR_ONE: begin
                  w_shift     = 1'b1;
                  w_state_nxt = ACK_LO;
               end
               DR_ILLEGAL: begin
                  w_bad       = 1'b1;
                  w_state_nxt = ACK_LO;
               end
               default: begin
                  // spacer with req low closes the packet
                  if (!i_rx_req) begin
                     if (w_slot_free) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                     end else begin
                        w_state_nxt = EMIT;
                     end
                  end
               end
            endcase
         end
         ACK_LO: begin
            if (i_rx_d == DR_SPACER) begin
               w_state_nxt = ACK_HI;
            end
         end
         EMIT: begin
            if (w_slot_free) begin
               w_push      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Shift register, saturating bit counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst || w_clr) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_shift) begin
            r_sr <= {r_sr[NOC_WID-2:0], i_rx_d[1]};
            if (r_cnt != '1) begin
               r_cnt <= r_cnt + CNT_WID'(1);
            end
            if (r_cnt >= CNT_WID'(NOC_WID)) begin
               r_err <= 1'b1;
            end
         end
         if (w_bad) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef NOC_RX_DESER_FIFO_EN
   logic               w_full;
   logic               w_empty;
   logic [PKT_WID-1:0] w_head;

   assign w_slot_free = !w_full || (o_out_valid && i_out_ready);
   assign o_out_valid = !w_empty;
   assign {o_out_err, o_out_bits, o_out_data} = w_head;

   noc_pkt_fifo #(
      .WID   (PKT_WID),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_pkt),
      .i_pop   (i_out_ready),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
`else
   logic               r_valid;
   logic [PKT_WID-1:0] r_out;

   assign w_slot_free = !r_valid || i_out_ready;
   assign o_out_valid = r_valid;
   assign {o_out_err, o_out_bits, o_out_data} = r_out;

   // Single-entry output register; reload on push, clear valid on pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_out   <= '0;
      end else if (w_push) begin
         r_valid <= 1'b1;
         r_out   <= w_pkt;
      end else if (r_valid && i_out_ready) begin
         r_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_noc_rx_deser.sv
// Self-checking bench for noc_rx_deser (works with or without NOC_RX_DESER_FIFO_EN).
`timescale 1ns/1ps
module tb_noc_rx_deser;
   import noc_pkg::*;

   localparam int unsigned NW = 16;
   localparam int unsigned CW = 8;
   localparam int unsigned DP = 4;
`ifdef NOC_RX_DESER_FIFO_EN
   localparam int STORE = DP;
`else
   localparam int STORE = 1;
`endif
   localparam int BUDGET  = 400;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct packed {
      logic          err;
      logic [CW-1:0] bits;
      logic [NW-1:0] data;
   } pkt_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_req = 1'b0;
   logic [1:0]    rx_d = 2'b00;
   logic          rx_ack;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [NW-1:0] out_data;
   logic [CW-1:0] out_bits;
   logic          out_err;

   int   errors = 0;
   int   checks = 0;
   int   lat_bad = 0;
   int   stab_bad = 0;
   bit   rand_ready = 1'b0;
   int   tx_q[$];
   pkt_t exp_q[$];
   pkt_t obs_q[$];
   pkt_t prev_out;
   logic prev_hold = 1'b0;

   always #5 clk = ~clk;

   noc_rx_deser #(.NOC_WID(NW), .CNT_WID(CW), .DEPTH(DP)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx_req    (rx_req),
      .i_rx_d      (rx_d),
      .o_rx_ack    (rx_ack),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_bits  (out_bits),
      .o_out_err   (out_err)
   );

   // consumer monitor: records popped packets and outputs moving while stalled
   always @(posedge clk) begin
      if (rst) begin
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold && ({out_valid, out_err, out_bits, out_data} !== {1'b1, prev_out}))
            stab_bad <= stab_bad + 1;
         if (out_valid && out_ready)
            obs_q.push_back(pkt_t'({out_err, out_bits, out_data}));
         prev_hold <= out_valid && !out_ready;
         prev_out  <= pkt_t'({out_err, out_bits, out_data});
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // reference: keep the last NW legal bits, count legal bits, flag illegal or overlong
   function automatic pkt_t model();
      longint unsigned d = 0;
      int   n = 0;
      logic e = 1'b0;
      pkt_t p;
      foreach (tx_q[i]) begin
         if (tx_q[i] == 2) e = 1'b1;
         else begin
            n++;
            d = ((d << 1) | longint'(tx_q[i])) & ((64'd1 << NW) - 64'd1);
            if (n > NW) e = 1'b1;
         end
      end
      p.err  = e;
      p.bits = CW'((n > CNT_MAX) ? CNT_MAX : n);
      p.data = NW'(d);
      return p;
   endfunction

   function automatic logic [1:0] code(input int s);
      return (s == 0) ? DR_ZERO : (s == 1) ? DR_ONE : DR_ILLEGAL;
   endfunction

   task automatic set_bits(input logic [31:0] v, input int n);
      tx_q.delete();
      for (int i = n - 1; i >= 0; i--) tx_q.push_back(int'((v >> i) & 32'd1));
   endtask

   task automatic wait_ack(input logic v);
      int lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (rx_ack !== v && lat < BUDGET);
      if (rx_ack !== v) begin
         checks++; errors++;
         $display("FAIL ack_timeout: rx_ack=%b want %b after %0d cycles", rx_ack, v, lat);
      end else if (lat != 1) lat_bad++;
   endtask

   // full 4-phase transfer of tx_q; expected result queued from the model
   task automatic send_pkt();
      exp_q.push_back(model());
      rx_req = 1'b1; rx_d = DR_SPACER;
      wait_ack(1'b1);
      foreach (tx_q[i]) begin
         rx_d = code(tx_q[i]);
         wait_ack(1'b0);
         rx_d = DR_SPACER;
         wait_ack(1'b1);
      end
      rx_req = 1'b0;
      wait_ack(1'b0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (obs_q.size() < exp_q.size() && n < BUDGET) begin
         @(posedge clk); #1; n++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      obs_q.delete(); exp_q.delete(); lat_bad = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_req = 1'b0; rx_d = DR_SPACER; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", rx_ack); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
      checks++; if (out_bits !== '0) begin errors++; $display("FAIL reset_bits: got %h want 0", out_bits); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", out_err); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL idle_ack: got %b want 0", rx_ack); end
   endtask

   task automatic test_8bit();
      clear_q(); out_ready = 1'b1;
      set_bits(32'hCA, 8);
      send_pkt();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b8_valid_latency: got %b want 1", out_valid); end
      checks++; if (out_data !== 16'h00CA) begin errors++; $display("FAIL b8_data: got %h want 00ca", out_data); end
      checks++; if (out_bits !== 8'd8) begin errors++; $display("FAIL b8_bits: got %0d want 8", out_bits); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL b8_err: got %b want 0", out_err); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b8_single_pulse: valid=%b want 0", out_valid); end
      wait_drain();
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL b8_pops: got %0d want 1", obs_q.size()); end
      checks++; if (lat_bad != 0) begin errors++; $display("FAIL b8_ack_latency: %0d edges not one cycle", lat_bad); end
   endtask

   task automatic test_16_17();
      clear_q(); out_ready = 1'b1;
      set_bits(32'hA5F0, 16);
      send_pkt();
      tx_q.push_back(1);
      send_pkt();
      wait_drain();
      checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL w16_count: got %0d want 2", obs_q.size()); end
      checks++; if (obs_q.size() < 1 || obs_q[0] !== pkt_t'({1'b0, 8'd16, 16'hA5F0}))
         begin errors++; $display("FAIL w16_pkt: got %h want %h", obs_q[0], pkt_t'({1'b0, 8'd16, 16'hA5F0})); end
      checks++; if (obs_q.size() < 2 || obs_q[1] !== pkt_t'({1'b1, 8'd17, 16'h4BE1}))
         begin errors++; $display("FAIL w17_overflow: got %h want %h", obs_q[1], pkt_t'({1'b1, 8'd17, 16'h4BE1})); end
   endtask

   task automatic test_illegal();
      clear_q(); out_ready = 1'b1;
      tx_q = '{1, 0, 2, 1};
      send_pkt();
      wait_drain();
      checks++; if (obs_q.size() != 1 || obs_q[0] !== pkt_t'({1'b1, 8'd3, 16'h0005}))
         begin errors++; $display("FAIL illegal_pkt: n=%0d got %h want %h", obs_q.size(), obs_q[0], pkt_t'({1'b1, 8'd3, 16'h0005})); end
      checks++; if (lat_bad != 0) begin errors++; $display("FAIL illegal_ack_latency: %0d edges not one cycle", lat_bad); end
   endtask

   task automatic test_zero();
      clear_q(); out_ready = 1'b1;
      tx_q.delete();
      send_pkt();
      wait_drain();
      checks++; if (obs_q.size() != 1 || obs_q[0] !== pkt_t'(0))
         begin errors++; $display("FAIL zero_pkt: n=%0d got %h want 0", obs_q.size(), obs_q[0]); end
   endtask

   task automatic test_backpressure();
      int stall_bad = 0;
      clear_q(); out_ready = 1'b0;
      for (int k = 0; k <= STORE; k++) begin
         set_bits(32'($urandom_range(0, 15)), 4);
         send_pkt();
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
      rx_req = 1'b1; rx_d = DR_SPACER;
      repeat (20) begin
         @(posedge clk); #1;
         if (rx_ack !== 1'b0) stall_bad++;
      end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_ack_withheld: ack high %0d cycles want 0", stall_bad); end
      out_ready = 1'b1;
      set_bits(32'($urandom_range(0, 15)), 4);
      send_pkt();
      wait_drain();
      checks++; if (obs_q.size() != STORE + 2) begin errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), STORE + 2); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_pkt%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_stable: %0d output changes while stalled", stab_bad); end
   endtask

   task automatic test_rst_mid();
      clear_q(); out_ready = 1'b0;
      tx_q = '{0, 1, 1, 0};
      send_pkt();
      rx_req = 1'b1; rx_d = DR_SPACER;
      wait_ack(1'b1);
      rx_d = DR_ONE;
      wait_ack(1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", rx_ack); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush: valid=%b want 0", out_valid); end
      rx_req = 1'b0; rx_d = DR_SPACER;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clear_q(); out_ready = 1'b1;
      set_bits(32'h3C, 8);
      send_pkt();
      wait_drain();
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rst_count: got %0d want 1", obs_q.size()); end
      checks++; if (obs_q.size() < 1 || obs_q[0] !== pkt_t'({1'b0, 8'd8, 16'h003C}))
         begin errors++; $display("FAIL rst_pkt: got %h want %h", obs_q[0], pkt_t'({1'b0, 8'd8, 16'h003C})); end
   endtask

   task automatic test_random();
      clear_q(); rand_ready = 1'b1;
      for (int k = 0; k < 25; k++) begin
         int len = int'($urandom_range(0, 20));
         tx_q.delete();
         for (int b = 0; b < len; b++)
            tx_q.push_back(($urandom_range(0, 15) == 0) ? 2 : int'($urandom_range(0, 1)));
         send_pkt();
      end
      rand_ready = 1'b0; out_ready = 1'b1;
      wait_drain();
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_pkt%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (stab_bad != 0) begin errors++; $display("FAIL rnd_stable: %0d output changes while stalled", stab_bad); end
   endtask

   initial begin
      test_reset();
      test_8bit();
      test_16_17();
      test_illegal();
      test_zero();
      test_backpressure();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
